// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 interrupt block.
//   Register numbers, SR/Cause bit positions, ExcCode values and the
//   exception-return address helper used when an exception is taken.
package cp0_pkg;

  // CP0 register numbers (mfc0/mtc0 rd field)
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR / Cause bit positions
  localparam int IE_BIT  = 0;
  localparam int EXL_BIT = 1;
  localparam int IM_LSB  = 10;
  localparam int IM_MSB  = 15;
  localparam int BD_BIT  = 31;
  localparam int EXC_LSB = 2;
  localparam int EXC_MSB = 6;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Return address for a taken exception: word-aligned PC, backed up to the
  // branch when the faulting instruction sits in a delay slot (wraps mod 2^32).
  function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] base;
    base = {pc[31:2], 2'b00};
    if (bd) begin
      return base - 32'd4;
    end else begin
      return base;
    end
  endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// cp0_int_arb: combinational interrupt/exception arbitration.
//   ip, im     : pending and mask interrupt bits
//   ie, exl    : global interrupt enable and exception level
//   exc_valid  : synchronous exception from the exception stage
//   exc_code   : ExcCode of that exception
//   take       : an interrupt or exception is taken this cycle
//   sel_code   : ExcCode to record (interrupt wins over the exception)
module cp0_int_arb
  import cp0_pkg::*;
#(
  parameter int HW_INT_W = 6
) (
  input  logic [HW_INT_W-1:0] ip,
  input  logic [HW_INT_W-1:0] im,
  input  logic                ie,
  input  logic                exl,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  output logic                take,
  output logic [4:0]          sel_code
);

  logic int_req_s;

  // Pending enabled interrupt, suppressed while already in exception level;
  // EXL also blocks synchronous exceptions.
  always_comb begin
    int_req_s = (|(ip & im)) & ie & ~exl;
    take      = (int_req_s | exc_valid) & ~exl;
    if (int_req_s) begin
      sel_code = EXC_INT;
    end else begin
      sel_code = exc_code;
    end
  end

endmodule

// File: rtl/cp0_int.sv
// cp0_int: coprocessor-0 register file and interrupt acceptance.
//   clk, rst          : clock, asynchronous active-low reset
//   a1 / dout         : mfc0 read register number and combinational read data
//   a2, din, we       : mtc0 write register number, data and enable
//   pc, bd            : exception-stage PC and branch-delay-slot flag
//   exc_valid/exc_code: synchronous exception request and its ExcCode
//   exl_clr           : eret, clears EXL
//   hw_int            : level-sensitive device interrupt lines (IP/IM 15:10)
//   take              : interrupt/exception taken this cycle
//   epc               : current EPC (eret target)
module cp0_int
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h0000_C500,
  parameter int          HW_INT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          a1,
  input  logic [4:0]          a2,
  input  logic [31:0]         din,
  input  logic                we,
  input  logic [31:0]         pc,
  input  logic                bd,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic                exl_clr,
  input  logic [HW_INT_W-1:0] hw_int,
  output logic                take,
  output logic [31:0]         epc,
  output logic [31:0]         dout
);

  logic [HW_INT_W-1:0] im_r;
  logic [HW_INT_W-1:0] ip_r;
  logic                exl_r;
  logic                ie_r;
  logic                bd_r;
  logic [4:0]          exc_code_r;
  logic [31:0]         epc_r;

  logic                take_s;
  logic [4:0]          sel_code_s;
  logic [31:0]         sr_s;
  logic [31:0]         cause_s;

  cp0_int_arb #(
    .HW_INT_W (HW_INT_W)
  ) u_arb (
    .ip        (ip_r),
    .im        (im_r),
    .ie        (ie_r),
    .exl       (exl_r),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .take      (take_s),
    .sel_code  (sel_code_s)
  );

  // CP0 state: IP sampling, exception entry, mtc0 writes and eret.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_r       <= {HW_INT_W{1'b0}};
      ip_r       <= {HW_INT_W{1'b0}};
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      exc_code_r <= 5'd0;
      epc_r      <= 32'd0;
    end else begin
      ip_r <= hw_int;
      if (take_s) begin
        // Exception entry overrides any mtc0 issued in the same cycle.
        exl_r      <= 1'b1;
        epc_r      <= exc_epc(pc, bd);
        bd_r       <= bd;
        exc_code_r <= sel_code_s;
      end else begin
        if (we) begin
          case (a2)
            REG_SR: begin
              im_r  <= din[IM_MSB:IM_LSB];
              exl_r <= din[EXL_BIT];
              ie_r  <= din[IE_BIT];
            end
            REG_EPC: begin
              epc_r <= {din[31:2], 2'b00};
            end
            default: begin
              // Cause, PRId and unmapped registers ignore writes.
            end
          endcase
        end
        // Placed after the write so eret wins over a same-cycle SR write.
        if (exl_clr) begin
          exl_r <= 1'b0;
        end
      end
    end
  end

  // Architectural views of SR and Cause; unimplemented bits read 0.
  always_comb begin
    sr_s    = {16'd0, im_r, 8'd0, exl_r, ie_r};
    cause_s = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'b00};
  end

  // mfc0 read port: pre-edge state, no write-through.
  always_comb begin
    case (a1)
      REG_SR:    dout = sr_s;
      REG_CAUSE: dout = cause_s;
      REG_EPC:   dout = epc_r;
      REG_PRID:  dout = PRID;
      default:   dout = 32'd0;
    endcase
  end

  assign take = take_s;
  assign epc  = epc_r;

endmodule

// File: tb/tb_cp0_int.sv
module tb_cp0_int;

  localparam int K_DOUT = 0;
  localparam int K_TAKE = 1;
  localparam int K_EPC  = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exl_clr;
  logic [5:0]  hw_int;
  logic        take;
  logic [31:0] epc;
  logic [31:0] dout;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] obs;
  int          checks   = 0;
  int          failures = 0;

  always #10 clk = ~clk;

  cp0_int #(
    .PRID     (32'h0000_C500),
    .HW_INT_W (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a1        (a1),
    .a2        (a2),
    .din       (din),
    .we        (we),
    .pc        (pc),
    .bd        (bd),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .exl_clr   (exl_clr),
    .hw_int    (hw_int),
    .take      (take),
    .epc       (epc),
    .dout      (dout)
  );

  // advance one clock; returns at the falling edge, state already updated
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input string n, input int k, input logic [4:0] a, input logic [31:0] v);
    exp_t x;
    x.name = n; x.kind = k; x.addr = a; x.val = v;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a1 = 5'd0; a2 = 5'd0; din = 32'd0; we = 1'b0; pc = 32'd0; bd = 1'b0;
    exc_valid = 1'b0; exc_code = 5'd0; exl_clr = 1'b0; hw_int = 6'd0;
    tick();
    tick();
    push("rst_sr",    K_DOUT, 5'd12, 32'd0);
    push("rst_cause", K_DOUT, 5'd13, 32'd0);
    push("rst_epc",   K_DOUT, 5'd14, 32'd0);
    push("rst_prid",  K_DOUT, 5'd15, 32'h0000_C500);
    push("rst_take",  K_TAKE, 5'd0,  32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    rst = 1'b1;
  endtask

  task automatic test_int_take();
    we = 1'b1; a2 = 5'd12; din = 32'h0000_0401;
    tick();
    we = 1'b0;
    hw_int = 6'h01; pc = 32'h0000_1000;
    push("int_take_before_sample", K_TAKE, 5'd0, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    push("int_take", K_TAKE, 5'd0, 32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    push("int_take_drop", K_TAKE, 5'd0,  32'd0);
    push("int_epc_reg",   K_DOUT, 5'd14, 32'h0000_1000);
    push("int_sr_exl",    K_DOUT, 5'd12, 32'h0000_0403);
    push("int_cause",     K_DOUT, 5'd13, 32'h0000_0400);
    push("int_epc_port",  K_EPC,  5'd0,  32'h0000_1000);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
  endtask

  task automatic test_masked();
    we = 1'b1; a2 = 5'd12; din = 32'h0000_0001; hw_int = 6'h3F;
    tick();
    we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      push($sformatf("masked_take_%0d", i), K_TAKE, 5'd0, 32'd0);
      push($sformatf("masked_cause_%0d", i), K_DOUT, 5'd13, 32'h0000_FC00);
      while (sb.size() != 0) begin
        e = sb.pop_front(); a1 = e.addr; #1;
        case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
        checks++;
        if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
      end
    end
    hw_int = 6'h00;
  endtask

  task automatic test_exception_bd();
    exc_valid = 1'b1; exc_code = 5'd12; bd = 1'b1; pc = 32'h0000_3010;
    push("exc_take", K_TAKE, 5'd0, 32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    exc_valid = 1'b0; bd = 1'b0;
    push("exc_epc_bd",   K_DOUT, 5'd14, 32'h0000_300C);
    push("exc_cause_bd", K_DOUT, 5'd13, 32'h8000_0030);
    push("exc_sr",       K_DOUT, 5'd12, 32'h0000_0003);
    push("exc_take_off", K_TAKE, 5'd0,  32'd0);
    push("exc_epc_port", K_EPC,  5'd0,  32'h0000_300C);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
  endtask

  task automatic test_priority_exl();
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    we = 1'b1; a2 = 5'd12; din = 32'h0000_0401; hw_int = 6'h01;
    tick();
    we = 1'b0;
    exc_valid = 1'b1; exc_code = 5'd4; pc = 32'h0000_2000;
    push("prio_take", K_TAKE, 5'd0, 32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    pc = 32'h0000_2100;
    push("exl_block_take", K_TAKE, 5'd0,  32'd0);
    push("prio_cause_int", K_DOUT, 5'd13, 32'h0000_0400);
    push("prio_epc",       K_DOUT, 5'd14, 32'h0000_2000);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    exc_valid = 1'b0;
    push("exl_epc_kept",   K_DOUT, 5'd14, 32'h0000_2000);
    push("exl_epc_port",   K_EPC,  5'd0,  32'h0000_2000);
    push("exl_cause_kept", K_DOUT, 5'd13, 32'h0000_0400);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
  endtask

  task automatic test_exl_clr_and_lost_write();
    exl_clr = 1'b1;
    push("eret_cycle_take", K_TAKE, 5'd0, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    exl_clr = 1'b0;
    pc = 32'h0000_4000;
    we = 1'b1; a2 = 5'd14; din = 32'hDEAD_BEE0;
    push("eret_sr",       K_DOUT, 5'd12, 32'h0000_0401);
    push("eret_retake",   K_TAKE, 5'd0,  32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    we = 1'b0;
    push("lost_write_epc",  K_DOUT, 5'd14, 32'h0000_4000);
    push("lost_write_sr",   K_DOUT, 5'd12, 32'h0000_0403);
    push("retake_cause",    K_DOUT, 5'd13, 32'h0000_0400);
    push("lost_write_port", K_EPC,  5'd0,  32'h0000_4000);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    hw_int = 6'h00;
  endtask

  task automatic test_mtc0_misc();
    we = 1'b1; a2 = 5'd14; din = 32'h1234_5677;
    tick();
    a2 = 5'd13; din = 32'hFFFF_FFFF;
    push("epc_align_reg",  K_DOUT, 5'd14, 32'h1234_5674);
    push("epc_align_port", K_EPC,  5'd0,  32'h1234_5674);
    push("prid_read",      K_DOUT, 5'd15, 32'h0000_C500);
    push("unmapped_read",  K_DOUT, 5'd3,  32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    a2 = 5'd12; din = 32'hFFFF_FFFF;
    push("cause_readonly", K_DOUT, 5'd13, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    a2 = 5'd12; din = 32'h0000_0403; exl_clr = 1'b1;
    push("sr_reserved_bits", K_DOUT, 5'd12, 32'h0000_FC03);
    push("sr_all_take",      K_TAKE, 5'd0,  32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    we = 1'b0; exl_clr = 1'b0;
    exc_valid = 1'b1; exc_code = 5'd10; bd = 1'b1; pc = 32'h0000_0000;
    push("sr_write_then_eret", K_DOUT, 5'd12, 32'h0000_0401);
    push("wrap_take",          K_TAKE, 5'd0,  32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    exc_valid = 1'b0; bd = 1'b0;
    push("wrap_epc",   K_DOUT, 5'd14, 32'hFFFF_FFFC);
    push("wrap_cause", K_DOUT, 5'd13, 32'h8000_0028);
    push("wrap_sr",    K_DOUT, 5'd12, 32'h0000_0403);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
  endtask

  task automatic test_async_reset();
    tick();
    #2;
    rst = 1'b0;
    push("arst_sr",    K_DOUT, 5'd12, 32'd0);
    push("arst_cause", K_DOUT, 5'd13, 32'd0);
    push("arst_epc",   K_DOUT, 5'd14, 32'd0);
    push("arst_take",  K_TAKE, 5'd0,  32'd0);
    push("arst_prid",  K_DOUT, 5'd15, 32'h0000_C500);
    while (sb.size() != 0) begin
      e = sb.pop_front(); a1 = e.addr; #1;
      case (e.kind) K_DOUT: obs = dout; K_TAKE: obs = {31'd0, take}; default: obs = epc; endcase
      checks++;
      if (obs !== e.val) begin failures++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.val); end
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_int_take();
    test_masked();
    test_exception_bd();
    test_priority_exl();
    test_exl_clr_and_lost_write();
    test_mtc0_misc();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0_int.md
Name: cp0_int

Overview:
- Coprocessor-0 block for the MIPS core: the consumer end of the peripheral interrupt lines.
- It samples the timer and other device interrupt requests and holds SR, Cause, EPC and PRId.
- It decides, cycle by cycle, whether the core takes an interrupt or exception. When one is taken it records EPC and the cause.
- Sits beside the pipeline's write-back/exception stage; mfc0/mtc0/eret are driven by the core.

Parameters:
- PRID, 32'h0000_C500, constant value returned for register 15.
- HW_INT_W, 6, number of hardware interrupt lines (maps to IP/IM bits 15:10).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- a1  input  5  CP0 read register number (mfc0).
- a2  input  5  CP0 write register number (mtc0).
- din  input  32  mtc0 write data.
- we  input  1  mtc0 write enable.
- pc  input  32  PC of the instruction in the exception stage.
- bd  input  1  that instruction sits in a branch delay slot.
- exc_valid  input  1  synchronous exception raised by that instruction.
- exc_code  input  5  ExcCode for exc_valid.
- exl_clr  input  1  eret: clear EXL.
- hw_int  input  6  device interrupt lines (bit 10 = timer irq), level-sensitive.
- take  output  1  exception/interrupt taken this cycle; core flushes and vectors.
- epc  output  32  current EPC (eret target).
- dout  output  32  read data for a1.

Behaviour:
- Reset (rst=0, async): SR=0, Cause=0, EPC=0.
  - take is then 0, because it is derived from those values.
  - dout follows a1 (PRID readable during reset).
- SR (reg 12) fields:
  - IM[15:10], EXL[1], IE[0].
  - All other bits read 0 and writes to them are ignored.
- Cause (reg 13) fields:
  - BD[31], IP[15:10], ExcCode[6:2]; other bits 0.
  - Read-only to mtc0: writes are dropped.
- EPC (reg 14): writable by mtc0; bits [1:0] are forced 0 on every write.
- PRId (reg 15): constant PRID.
- Unmapped register numbers: read 0, writes ignored.
- IP sampling: IP <= hw_int every cycle, regardless of EXL/IE. Sampling latency is one cycle, so device irq at edge N is visible in IP after edge N.
- Interrupt request: int_req = |(IP & IM) & IE & ~EXL (combinational from registered state).
- take = (int_req | exc_valid) & ~EXL, combinational.
  - A synchronous exception while EXL=1 is not taken.
- On a clock edge with take=1, all four updates below happen together:
  - EXL <= 1.
  - EPC <= bd ? {pc[31:2],2'b00} - 4 : {pc[31:2],2'b00}.
  - BD <= bd.
  - ExcCode <= int_req ? 5'd0 : exc_code. Interrupt has priority over a simultaneous synchronous exception.
- exl_clr=1 (and take=0): EXL <= 0. Other fields are unchanged.
- Simultaneous events:
  - take and we in the same cycle: the mtc0 write is discarded entirely; take updates win.
  - exl_clr and we to SR in the same cycle: the write is applied first, then EXL is forced 0.
  - exl_clr with EXL already 0: no effect.
  - EPC write with a BD slot: the subtraction wraps modulo 2^32 (pc=0, bd=1 gives EPC=32'hFFFF_FFFC).
- dout: combinational mux on a1 with no read latency. Reads reflect pre-edge state; there is no write-through bypass.
- epc output = EPC register.

Decomposition:
- Shared package cp0_pkg:
  - Register numbers: SR=12, CAUSE=13, EPC=14, PRID=15.
  - Bit positions: IE, EXL, IM/IP lsb/msb, BD, ExcCode range.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
- One sub-module is natural: cp0_int_arb, the combinational int_req/take/ExcCode select, so the priority rules are unit-testable. The register file stays in cp0_int.

Test Plan:
- Reset release, then mtc0 SR=32'h0000_0401, hw_int[0]=1:
  - take=1 one cycle after hw_int rises.
  - EPC=pc, ExcCode=0, EXL=1.
  - take returns to 0 next cycle.
- IE=1, IM=0, hw_int=6'h3F held 10 cycles:
  - take stays 0; Cause reads 32'h0000_FC00.
- exc_valid=1, exc_code=12, bd=1, pc=32'h0000_3010, EXL=0:
  - EPC=32'h0000_300C, Cause=32'h8000_0030, take=1.
- exc_valid=1 (code 4) together with an enabled pending interrupt: ExcCode=0. Then exc_valid=1 again while EXL=1: take=0 and EPC unchanged.
- exl_clr pulse after a taken interrupt with hw_int still high: EXL=0 and take=1 in the following cycle.
- mtc0 EPC=32'h1234_5677 → reads 32'h1234_5674. mtc0 in the same cycle as take → write lost. Read reg 15 → PRID. Read reg 3 → 0. Assert rst mid-operation → SR/Cause/EPC read 0 immediately.
